uart_rx_os: RTL and testbench
=============================

// Module: uart_rx_os
// PURPOSE
//  Oversampling 8N1 UART receiver. Sits directly upstream of cmd_parser.
//  Turns the serial RX pin into a byte stream: rxd_data plus a one-cycle rxd_data_ready strobe.
//  Rejects start-bit glitches, majority-votes each bit and flags framing errors/breaks.
//  No backpressure: the consumer samples on the strobe.
// PARAMETERS
//  CLK_FREQ    12_000_000  system clock frequency, Hz
//  BAUD        115_200     line rate, bit/s
//  OVERSAMPLE  8           oversample ticks per bit; even, >= 4
// PORTS
//  clk             in   1  system clock; single clock domain
//  reset           in   1  synchronous, active-high reset
//  rxd             in   1  asynchronous serial input; idle high
//  rxd_data        out  8  last good byte; LSB received first
//  rxd_data_ready  out  1  one-cycle strobe; rxd_data is valid in the same cycle
//  frame_err       out  1  one-cycle strobe: stop bit sampled low
//  busy            out  1  high when the state is not IDLE
// BEHAVIOUR
//  Reset values: rxd_data=0, rxd_data_ready=0, frame_err=0, busy=0.
//    Synchronizer flops reset to 1. State resets to IDLE.
//  Synchronizer: rxd passes through 2 flops (rx_s). All logic uses rx_s only.
//  Tick generator:
//    - DIV = round(CLK_FREQ / (BAUD*OVERSAMPLE)); defaults give DIV=13, 0.2% error.
//    - Counter runs DIV-1..0 and pulses os_tick at 0.
//    - Reloads to DIV-1 on the IDLE->START transition so ticks are aligned to the edge.
//  os_cnt: 0..OVERSAMPLE-1, advances on os_tick and wraps. Cleared on entering START.
//  Vote: rx_s is sampled at os_cnt = M-1, M and M+1, where M = OVERSAMPLE/2.
//    The bit value is the majority of the 3 samples, decided on the M+1 tick.
//  State IDLE:
//    - rx_s==0 -> START.
//  State START:
//    - vote==0 -> DATA, bit_cnt=0.
//    - vote==1 -> IDLE. This is a false start; no strobe is issued.
//  State DATA:
//    - At each vote, shift the bit in as {vote, sh[7:1]}.
//    - bit_cnt 0..7; after bit 7 -> STOP.
//  State STOP (vote taken mid-bit):
//    - vote==1: rxd_data<=sh; rxd_data_ready=1 for the next cycle only; -> IDLE.
//      Returning at mid stop bit lets the next start edge be caught back-to-back.
//    - vote==0: frame_err=1 for one cycle; rxd_data unchanged; -> BREAK.
//  State BREAK:
//    - Wait for rx_s==1, then -> IDLE. A held-low line never retriggers START.
//  Latency: rxd_data_ready fires ~9.5 bit times + 3 clk after the falling start edge.
//  Strobes: rxd_data_ready and frame_err are mutually exclusive and never last >1 cycle.
//  Reset mid-byte: aborts immediately, all outputs go to reset values.
//    A partial byte is never delivered.
//  Counters are sized from $clog2 of their ranges; no overflow is possible by construction.
//  Unused state encodings -> IDLE.
// STRUCTURE
//  Shared include uart_defs.vh:
//    - state encodings IDLE/START/DATA/STOP/BREAK
//    - DIV computation macro
//    - 8N1 frame constants (DATA_BITS=8, STOP_BITS=1)
//  Sub-module baud_tick_gen (DIV parameter; inputs clk, reset, restart; output os_tick).
//    Reused later by the transmitter.
// TESTING (bench drives rxd at BAUD, defaults unless stated)
//  1. Byte 0x02 -> single rxd_data_ready pulse, rxd_data=0x02, frame_err stays 0, busy low after.
//  2. Bytes 0x01..0x10 back-to-back, 1 stop bit each -> 16 strobes in order, no drops.
//  3. Low glitch of 2 os ticks (< M-1), then idle -> no strobes; state returns to IDLE.
//  4. 0x55 with stop bit forced 0, line held low for 3 bit times, then 0xA5 ->
//     one frame_err pulse, no rxd_data_ready for 0x55, then rxd_data=0xA5 with a strobe.
//  5. reset pulsed at data bit 4 of 0x3C, then full byte 0xC3 ->
//     outputs reset to 0, no strobe for 0x3C, then rxd_data=0xC3.
//  6. Bytes 0x00, 0xFF, 0x5A sent at BAUD +3% and -3% -> all received correctly, no frame_err.

Source files
------------

// File: rtl/uart_rx_os_pkg.sv
// Shared definitions for the oversampling UART receiver (and the matching transmitter).
//  - FSM state encodings
//  - 8N1 frame constants
//  - oversample divider computation and a 3-input majority helper
package uart_rx_os_pkg;

    // Receiver FSM state encodings
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    // 8N1 frame
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Depth of the rxd metastability synchronizer
    localparam int SYNC_STAGES = 2;

    // round(clk_freq / (baud * oversample)) using integer arithmetic
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int denom;
        denom = baud * oversample;
        return (clk_freq + denom / 2) / denom;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_os_baud_tick_gen.sv
// Oversample tick generator.
//  A down-counter runs DIV-1..0 and pulses os_tick while it sits at 0.
//  restart reloads the counter so the tick phase lines up with an external event
//  (the receiver uses it on the start-bit edge).
// Ports:
//  clk      in  system clock
//  reset    in  synchronous active-high reset
//  restart  in  reload the counter to DIV-1
//  os_tick  out one-cycle pulse every DIV clocks
module baud_tick_gen #(
    parameter int DIV = 13
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic os_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg - 1'b1;
        if (restart || (cnt_reg == '0)) begin
            cnt_next = RELOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= RELOAD;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign os_tick = (cnt_reg == '0);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver.
//  Converts the asynchronous rxd pin into bytes with a one-cycle ready strobe.
//  Start-bit glitches are rejected, each bit is a 3-sample majority vote taken
//  around mid-bit, and a low stop bit raises frame_err and parks the receiver in
//  BREAK until the line returns high.
// Ports:
//  clk             in   system clock
//  reset           in   synchronous active-high reset
//  rxd             in   asynchronous serial input, idle high
//  rxd_data        out  last good byte, LSB received first
//  rxd_data_ready  out  one-cycle strobe, rxd_data valid in the same cycle
//  frame_err       out  one-cycle strobe, stop bit sampled low
//  busy            out  high whenever the FSM is not IDLE
module uart_rx_os
    import uart_rx_os_pkg::*;
#(
    parameter int CLK_FREQ   = 12_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rxd_data,
    output logic       rxd_data_ready,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam int OCW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS);

    localparam logic [OCW-1:0] OS_LAST = OCW'(OVERSAMPLE - 1);
    localparam logic [OCW-1:0] SAMP_A  = OCW'(M - 1);
    localparam logic [OCW-1:0] SAMP_B  = OCW'(M);
    localparam logic [OCW-1:0] SAMP_C  = OCW'(M + 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Input synchronizer; everything downstream sees rx_s only
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   rx_s;

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            assign sync_next[gi] = rxd;
        end else begin : g_chain
            assign sync_next[gi] = sync_reg[gi-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= sync_next;
        end
    end

    assign rx_s = sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Oversample tick, realigned to the start edge
    // ------------------------------------------------------------------
    logic restart;
    logic os_tick;

    baud_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .os_tick(os_tick)
    );

    // ------------------------------------------------------------------
    // Datapath and FSM registers
    // ------------------------------------------------------------------
    logic [2:0]     state_reg;
    logic [2:0]     state_next;
    logic [OCW-1:0] os_cnt_reg;
    logic [BCW-1:0] bit_cnt_reg;
    logic [7:0]     sh_reg;
    logic [1:0]     samp_reg;      // samples taken at M-1 and M
    logic [7:0]     rxd_data_reg;
    logic           ready_reg;
    logic           ferr_reg;

    logic vote_tick;
    logic vote;

    // The third sample is the live rx_s on the M+1 tick, so the decision
    // needs no extra register stage.
    assign vote_tick = os_tick && (os_cnt_reg == SAMP_C);
    assign vote      = majority3(samp_reg[0], samp_reg[1], rx_s);

    always_comb begin
        state_next = state_reg;
        restart    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_next = ST_START;
                    restart    = 1'b1;
                end
            end
            ST_START: begin
                if (vote_tick) begin
                    state_next = vote ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (vote_tick && (bit_cnt_reg == BIT_LAST)) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leaving at mid stop bit lets a back-to-back start edge be caught.
                if (vote_tick) begin
                    state_next = vote ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                // Only a return to idle-high rearms; a held-low line is ignored.
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            os_cnt_reg   <= '0;
            bit_cnt_reg  <= '0;
            sh_reg       <= '0;
            samp_reg     <= '0;
            rxd_data_reg <= '0;
            ready_reg    <= 1'b0;
            ferr_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            ready_reg <= 1'b0;
            ferr_reg  <= 1'b0;

            if (restart) begin
                os_cnt_reg <= '0;
            end else if (os_tick) begin
                os_cnt_reg <= (os_cnt_reg == OS_LAST) ? '0 : os_cnt_reg + 1'b1;
            end

            if (os_tick && (os_cnt_reg == SAMP_A)) begin
                samp_reg[0] <= rx_s;
            end
            if (os_tick && (os_cnt_reg == SAMP_B)) begin
                samp_reg[1] <= rx_s;
            end

            if (vote_tick) begin
                case (state_reg)
                    ST_START: begin
                        bit_cnt_reg <= '0;
                    end
                    ST_DATA: begin
                        sh_reg      <= {vote, sh_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                    ST_STOP: begin
                        if (vote) begin
                            rxd_data_reg <= sh_reg;
                            ready_reg    <= 1'b1;
                        end else begin
                            ferr_reg <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign rxd_data       = rxd_data_reg;
    assign rxd_data_ready = ready_reg;
    assign frame_err      = ferr_reg;
    assign busy           = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: drives serial frames at (or near) the
// line rate and compares the observed strobe/event stream with the events a
// well-formed or malformed frame must produce.
module tb_uart_rx_os;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] rxd_data;
    logic       rxd_data_ready;
    logic       frame_err;
    logic       busy;

    uart_rx_os dut (
        .clk           (clk),
        .reset         (reset),
        .rxd           (rxd),
        .rxd_data      (rxd_data),
        .rxd_data_ready(rxd_data_ready),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    localparam real BIT_NOM = 12000000.0 / 115200.0;   // clocks per bit
    localparam int  OS_TICK = 13;                       // clocks per oversample tick

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Event = {is_frame_err, data}
    logic [8:0] ev_q[$];
    logic [8:0] exp_q[$];
    int         overlap_cnt = 0;
    int         long_cnt    = 0;
    logic       prev_rdy    = 1'b0;
    logic       prev_fe     = 1'b0;

    always @(negedge clk) begin
        if (rxd_data_ready) ev_q.push_back({1'b0, rxd_data});
        if (frame_err)      ev_q.push_back({1'b1, 8'h00});
        if (rxd_data_ready && frame_err) overlap_cnt++;
        if ((rxd_data_ready && prev_rdy) || (frame_err && prev_fe)) long_cnt++;
        prev_rdy = rxd_data_ready;
        prev_fe  = frame_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame at bp clocks per bit; records the event it should cause.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input real bp);
        logic [9:0] bits;
        real        t;
        int         done;
        int         n;
        bits = {stop_v, b, 1'b0};
        t    = 0.0;
        done = 0;
        for (int i = 0; i < 10; i++) begin
            rxd  = bits[i];
            t    = t + bp;
            n    = $rtoi(t + 0.5) - done;
            repeat (n) @(negedge clk);
            done = done + n;
        end
        if (stop_v) exp_q.push_back({1'b0, b});
        else        exp_q.push_back({1'b1, 8'h00});
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic compare_events(input string tag);
        int n_obs;
        int n_exp;
        n_obs = ev_q.size();
        n_exp = exp_q.size();
        check({tag, "_count"}, n_obs, n_exp);
        for (int i = 0; i < n_exp && i < n_obs; i++) begin
            check($sformatf("%s_ev%0d", tag, i), {23'd0, ev_q[i]}, {23'd0, exp_q[i]});
        end
        ev_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] rb;
        logic [9:0] pbits;
        int         gap;

        // ---------------- reset state ----------------
        reset = 1'b1;
        idle_cycles(5);
        reset = 1'b0;
        idle_cycles(20);
        check("rst_data",  {24'd0, rxd_data}, 32'h00);
        check("rst_ready", {31'd0, rxd_data_ready}, 32'd0);
        check("rst_ferr",  {31'd0, frame_err}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        $display("step reset: data=%02h busy=%0b", rxd_data, busy);

        // ---------------- single byte 0x02 ----------------
        send_frame(8'h02, 1'b1, BIT_NOM);
        wait_idle("t1");
        idle_cycles(20);
        compare_events("t1");
        check("t1_data", {24'd0, rxd_data}, 32'h02);
        $display("step t1: byte 0x02 -> rxd_data=%02h", rxd_data);

        // ---------------- 0x01..0x10 back-to-back ----------------
        for (int i = 1; i <= 16; i++) begin
            send_frame(8'(i), 1'b1, BIT_NOM);
        end
        wait_idle("t2");
        idle_cycles(20);
        compare_events("t2");
        $display("step t2: 16 back-to-back bytes, last rxd_data=%02h", rxd_data);

        // ---------------- short start glitch ----------------
        rxd = 1'b0;
        idle_cycles(2 * OS_TICK);
        rxd = 1'b1;
        idle_cycles($rtoi(2.0 * BIT_NOM));
        wait_idle("t3");
        compare_events("t3");
        $display("step t3: glitch of 2 ticks, busy=%0b", busy);

        // ---------------- framing error / break, then 0xA5 ----------------
        send_frame(8'h55, 1'b0, BIT_NOM);
        check("t4_hold_data", {24'd0, rxd_data}, 32'h10);
        check("t4_in_break", {31'd0, busy}, 32'd1);
        idle_cycles($rtoi(3.0 * BIT_NOM));
        check("t4_still_break", {31'd0, busy}, 32'd1);
        rxd = 1'b1;
        idle_cycles($rtoi(2.0 * BIT_NOM));
        send_frame(8'hA5, 1'b1, BIT_NOM);
        wait_idle("t4");
        idle_cycles(20);
        compare_events("t4");
        check("t4_data", {24'd0, rxd_data}, 32'hA5);
        $display("step t4: break then 0xA5 -> rxd_data=%02h", rxd_data);

        // ---------------- reset mid-byte at data bit 4 of 0x3C ----------------
        pbits = {1'b1, 8'h3C, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rxd = pbits[i];
            idle_cycles($rtoi(BIT_NOM));
        end
        rxd = pbits[5];                 // data bit 4 (high); sender aborts after this
        idle_cycles(50);
        check("t5_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_data",  {24'd0, rxd_data}, 32'h00);
        check("t5_rst_ready", {31'd0, rxd_data_ready}, 32'd0);
        check("t5_rst_ferr",  {31'd0, frame_err}, 32'd0);
        check("t5_rst_busy",  {31'd0, busy}, 32'd0);
        reset = 1'b0;
        rxd   = 1'b1;
        idle_cycles($rtoi(2.0 * BIT_NOM));
        send_frame(8'hC3, 1'b1, BIT_NOM);
        wait_idle("t5");
        idle_cycles(20);
        compare_events("t5");
        check("t5_data", {24'd0, rxd_data}, 32'hC3);
        $display("step t5: reset mid-byte then 0xC3 -> rxd_data=%02h", rxd_data);

        // ---------------- +/-3% baud ----------------
        send_frame(8'h00, 1'b1, BIT_NOM / 1.03);
        send_frame(8'hFF, 1'b1, BIT_NOM / 1.03);
        send_frame(8'h5A, 1'b1, BIT_NOM / 1.03);
        wait_idle("t6f");
        idle_cycles(20);
        compare_events("t6f");
        $display("step t6f: +3%% baud bytes, last rxd_data=%02h", rxd_data);
        send_frame(8'h00, 1'b1, BIT_NOM / 0.97);
        send_frame(8'hFF, 1'b1, BIT_NOM / 0.97);
        send_frame(8'h5A, 1'b1, BIT_NOM / 0.97);
        wait_idle("t6s");
        idle_cycles(20);
        compare_events("t6s");
        $display("step t6s: -3%% baud bytes, last rxd_data=%02h", rxd_data);

        // ---------------- random bytes with random idle gaps ----------------
        for (int k = 0; k < 8; k++) begin
            rb  = 8'($urandom_range(0, 255));
            gap = $urandom_range(0, 3) * 52;
            send_frame(rb, 1'b1, BIT_NOM);
            idle_cycles(gap);
            $display("step rnd%0d: sent %02h gap %0d", k, rb, gap);
        end
        wait_idle("rnd");
        idle_cycles(20);
        compare_events("rnd");

        // ---------------- strobe properties over the whole run ----------------
        check("strobe_overlap", overlap_cnt, 32'd0);
        check("strobe_width",   long_cnt, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
